// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared state type, default pattern and width helpers
package pattern_scan_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, RELEASE} state_t;

    localparam int PAT_W_DEF = 6;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 6'b101011;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pattern_scan_arbiter_if.sv
// pattern_scan_arbiter_if: requester bundle and result strobes of the shared scanner
interface pattern_scan_arbiter_if
    import pattern_scan_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 16
) ();

    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = cnt_w(FRAME_LEN);

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  din;
    logic [NREQ-1:0]  din_vld;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             hit;
    logic [ID_W-1:0]  hit_id;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic [CNT_W-1:0] done_cnt;
    logic             done_abort;

    modport master (
        output req, din, din_vld,
        input  gnt, busy, hit, hit_id, done, done_id, done_cnt, done_abort
    );

    modport slave (
        input  req, din, din_vld,
        output gnt, busy, hit, hit_id, done, done_id, done_cnt, done_abort
    );

endinterface

// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine: serial pattern detector with bit and match counters for one frame
module pattern_scan_engine
    import pattern_scan_pkg::*;
#(
    parameter int                PAT_W     = PAT_W_DEF,
    parameter logic [PAT_W-1:0]  PATTERN   = PAT_W'(PATTERN_DEF),
    parameter int                FRAME_LEN = 16,
    localparam int               CNT_W     = cnt_w(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             i_clear,
    input  logic             i_bit,
    input  logic             i_valid,
    output logic             o_hit,
    output logic             o_last,
    output logic [CNT_W-1:0] o_count
);

    logic [PAT_W-1:0] r_hist;
    logic [CNT_W-1:0] r_bitcnt;
    logic [CNT_W-1:0] r_matchcnt;
    logic [PAT_W-1:0] w_hist;
    logic [CNT_W-1:0] w_bitcnt_nx;

    // o_hit/o_last describe the bit being accepted now; o_count is the match count after it
    always_comb begin
        w_hist      = {r_hist[PAT_W-2:0], i_bit};
        w_bitcnt_nx = r_bitcnt + 1'b1;
        o_hit       = i_valid && (w_hist == PATTERN) && (w_bitcnt_nx >= CNT_W'(PAT_W));
        o_last      = i_valid && (w_bitcnt_nx == CNT_W'(FRAME_LEN));
        o_count     = (o_hit && r_matchcnt != CNT_W'(FRAME_LEN)) ? r_matchcnt + 1'b1 : r_matchcnt;
    end

    // shift history and counters; overlapping matches keep the history intact
    always_ff @(posedge clk) begin
        if (r || i_clear) begin
            r_hist     <= '0;
            r_bitcnt   <= '0;
            r_matchcnt <= '0;
        end else if (i_valid) begin
            r_hist     <= w_hist;
            r_bitcnt   <= w_bitcnt_nx;
            r_matchcnt <= o_count;
        end
    end

endmodule

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: round-robin sharing of one pattern-scan engine across requesters
module pattern_scan_arbiter
    import pattern_scan_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               PAT_W     = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(PATTERN_DEF),
    parameter int               FRAME_LEN = 16
) (
    input  logic                   clk,
    input  logic                   r,
    pattern_scan_arbiter_if.slave  bus
);

    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = cnt_w(FRAME_LEN);
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

    state_t           r_state;
    state_t           w_state_nx;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic             r_busy;
    logic             r_hit;
    logic [ID_W-1:0]  r_hit_id;
    logic             r_done;
    logic [ID_W-1:0]  r_done_id;
    logic [CNT_W-1:0] r_done_cnt;
    logic             r_done_abort;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [ID_W-1:0]   w_off;
    logic [ID_W:0]     w_sum;
    logic [ID_W-1:0]   w_pick;
    logic              w_own_req;
    logic              w_valid;
    logic              w_hit;
    logic              w_last;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_abort;
    logic              w_done;

    // rotate requests so bit 0 is the pointer position, then take the lowest set offset
    always_comb begin
        w_dbl = {bus.req, bus.req} >> r_ptr;
        w_rot = w_dbl[NREQ-1:0];
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = ID_W'(k);
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= NREQ_W) ? ID_W'(w_sum - NREQ_W) : w_sum[ID_W-1:0];
    end

    assign w_own_req = bus.req[r_owner];
    assign w_valid   = (r_state == SCAN) && w_own_req && bus.din_vld[r_owner];

    pattern_scan_engine #(
        .PAT_W     (PAT_W),
        .PATTERN   (PATTERN),
        .FRAME_LEN (FRAME_LEN)
    ) u_engine (
        .clk     (clk),
        .r       (r),
        .i_clear (r_state == IDLE),
        .i_bit   (bus.din[r_owner]),
        .i_valid (w_valid),
        .o_hit   (w_hit),
        .o_last  (w_last),
        .o_count (w_cnt)
    );

    // next state: a frame ends on its last valid bit or when the owner drops req
    always_comb begin
        w_abort    = (r_state == SCAN) && !w_own_req;
        w_done     = w_abort || w_last;
        w_state_nx = (r_state == IDLE) ? ((|bus.req) ? SCAN : IDLE) :
                     (r_state == SCAN) ? (w_done ? RELEASE : SCAN) : IDLE;
    end

    // state, owner latch at grant time and pointer advance on release
    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE) r_owner <= w_pick;
            if (r_state == RELEASE) r_ptr <= (r_owner == ID_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    // registered outputs; ids and counts hold between strobes
    always_ff @(posedge clk) begin
        if (r) begin
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_id     <= '0;
            r_done       <= 1'b0;
            r_done_id    <= '0;
            r_done_cnt   <= '0;
            r_done_abort <= 1'b0;
        end else begin
            r_gnt  <= (r_state == IDLE && |bus.req) ? NREQ'(1) << w_pick :
                      (r_state == RELEASE) ? '0 : r_gnt;
            r_busy <= (r_state == IDLE && |bus.req) ? 1'b1 :
                      (r_state == RELEASE) ? 1'b0 : r_busy;
            r_hit  <= w_hit;
            r_done <= w_done;
            if (w_hit) r_hit_id <= r_owner;
            if (w_done) begin
                r_done_id    <= r_owner;
                r_done_cnt   <= w_cnt;
                r_done_abort <= w_abort;
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.busy       = r_busy;
    assign bus.hit        = r_hit;
    assign bus.hit_id     = r_hit_id;
    assign bus.done       = r_done;
    assign bus.done_id    = r_done_id;
    assign bus.done_cnt   = r_done_cnt;
    assign bus.done_abort = r_done_abort;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb_pattern_scan_arbiter: directed checks of grant order, hits, frame summaries and reset
module tb_pattern_scan_arbiter;

    logic clk = 1'b0;
    logic r   = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    pattern_scan_arbiter_if bus ();

    pattern_scan_arbiter dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.req     = '0;
        bus.din     = '0;
        bus.din_vld = '0;
        r = 1'b1;
        tick();
        r = 1'b0;
    endtask

    // streams 16 valid bits (MSB first) for an already granted owner
    task automatic frame(input int own, input logic [15:0] bits, input logic [15:0] hits,
                         input int cnt);
        chk("frame_gnt", bus.gnt, 32'(1) << own);
        bus.din_vld      = '0;
        bus.din_vld[own] = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            bus.din[own] = bits[i];
            tick();
            chk("frame_hit", bus.hit, hits[i]);
            if (hits[i]) chk("frame_hit_id", bus.hit_id, own);
            chk("frame_done", bus.done, i == 0);
        end
        chk("frame_done_id", bus.done_id, own);
        chk("frame_done_cnt", bus.done_cnt, cnt);
        chk("frame_done_abort", bus.done_abort, 0);
    endtask

    // one cycle of release with grant low, then the next grant appears
    task automatic regrant(input logic [3:0] g);
        tick();
        chk("rel_gnt", bus.gnt, 0);
        chk("rel_busy", bus.busy, 0);
        chk("rel_done", bus.done, 0);
        tick();
        chk("regrant", bus.gnt, g);
    endtask

    initial begin
        logic [5:0] pat;
        pat = 6'b101011;

        do_reset();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_cnt", bus.done_cnt, 0);

        bus.req = 4'b0001;
        tick();
        chk("t1_busy", bus.busy, 1);
        frame(0, 16'b1010110101100000, 16'b0000010000100000, 2);
        chk("t1_gnt_in_release", bus.gnt, 4'b0001);
        bus.req = '0;
        tick();
        chk("t1_gnt_off", bus.gnt, 0);
        chk("t1_cnt_hold", bus.done_cnt, 2);

        do_reset();
        bus.req = 4'b1111;
        tick();
        for (int f = 0; f < 5; f++) begin
            frame(f % 4, 16'h0000, 16'h0000, 0);
            if (f < 4) regrant(4'(1 << ((f + 1) % 4)));
        end
        bus.req = '0;
        tick();
        tick();

        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("t3_gnt", bus.gnt, 4'b0100);
        for (int i = 0; i < 12; i++) begin
            bus.din_vld[2] = (i % 2 == 0);
            bus.din[2]     = (i % 2 == 0) ? pat[5 - i / 2] : ~pat[5 - i / 2];
            tick();
            chk("t3_hit", bus.hit, i == 10);
            chk("t3_done_early", bus.done, 0);
        end
        chk("t3_hit_id", bus.hit_id, 2);
        bus.din_vld[2] = 1'b1;
        bus.din[2]     = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("t3_done", bus.done, j == 9);
        end
        chk("t3_done_cnt", bus.done_cnt, 1);
        chk("t3_done_id", bus.done_id, 2);
        bus.req = '0;
        tick();
        tick();

        do_reset();
        bus.req     = 4'b0010;
        bus.din_vld = 4'b0010;
        tick();
        chk("t4_gnt", bus.gnt, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            bus.din[1] = (i % 2 == 0);
            tick();
        end
        bus.req    = '0;
        bus.din[1] = 1'b1;
        tick();
        chk("t4_done", bus.done, 1);
        chk("t4_abort", bus.done_abort, 1);
        chk("t4_done_id", bus.done_id, 1);
        chk("t4_done_cnt", bus.done_cnt, 0);
        tick();
        chk("t4_done_off", bus.done, 0);
        chk("t4_gnt_off", bus.gnt, 0);
        chk("t4_busy_off", bus.busy, 0);
        chk("t4_abort_hold", bus.done_abort, 1);

        bus.req     = 4'b1000;
        bus.din_vld = 4'b1000;
        bus.din     = 4'b1000;
        tick();
        chk("t6_gnt", bus.gnt, 4'b1000);
        tick();
        tick();
        tick();
        r       = 1'b1;
        bus.req = 4'b1001;
        tick();
        chk("t6_rst_gnt", bus.gnt, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done", bus.done, 0);
        chk("t6_rst_abort", bus.done_abort, 0);
        chk("t6_rst_done_id", bus.done_id, 0);
        r = 1'b0;
        tick();
        chk("t6_regrant_ptr0", bus.gnt, 4'b0001);
        chk("t6_no_done", bus.done, 0);

        do_reset();
        bus.req = 4'b0001;
        tick();
        frame(0, 16'b0000000000101011, 16'b0000000000000001, 1);
        regrant(4'b0001);
        frame(0, 16'b0000000000010101, 16'h0000, 0);
        regrant(4'b0001);
        frame(0, 16'b1000000000000000, 16'h0000, 0);
        bus.req = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
- Shares one serial pattern-scan engine (a 6-bit "101011" detector) between NREQ bit-stream requesters.
- Round-robin arbiter grants one requester a frame of FRAME_LEN valid bits, during which the engine scans that requester's stream.
- The engine is cleared between frames.
- Reports a per-hit pulse, then an end-of-frame summary (match count, abort flag) tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PAT_W, 6, pattern length in bits.
- PATTERN, 6'b101011, pattern to detect; MSB is the first bit received.
- FRAME_LEN, 16, valid bits per granted frame (must be >= PAT_W).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- r  in  1  reset, synchronous, active-high.
- req  in  NREQ  level request per requester; held high until the frame is done.
- din  in  NREQ  serial data bit per requester.
- din_vld  in  NREQ  data-valid per requester; only the owner's bit is used.
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high while a frame is owned (SCAN state).
- hit  out  1  one-cycle pulse on a pattern match.
- hit_id  out  $clog2(NREQ)  owner id, valid with hit.
- done  out  1  one-cycle end-of-frame pulse.
- done_id  out  $clog2(NREQ)  owner id of the completed frame.
- done_cnt  out  $clog2(FRAME_LEN+1)  matches found in the frame.
- done_abort  out  1  with done: the frame ended early because req dropped.

Behaviour:
- Reset: on r=1 at an edge, all outputs go to 0, state goes to IDLE, the round-robin pointer goes to 0, and the history, bit counter and match counter clear. Reset overrides everything, including mid-frame; no done is emitted for a frame killed by reset.
- States: IDLE, SCAN, RELEASE.
- IDLE:
  - If req != 0, choose the first set req at or after index ptr (ptr=0 after reset), wrapping modulo NREQ.
  - Next cycle: gnt[owner]=1, busy=1, state=SCAN; history, bit count and match count cleared.
  - If req==0, stay in IDLE.
- SCAN, each cycle:
  - If req[owner]=0: done=1, done_abort=1, done_cnt=matches so far, go to RELEASE. The current bit is ignored.
  - Else if din_vld[owner]=1:
    - history <= {history[PAT_W-2:0], din[owner]}; bitcnt++.
    - If the new history equals PATTERN and bitcnt+1 >= PAT_W, then next cycle hit=1, hit_id=owner, matchcnt++.
    - If bitcnt+1 == FRAME_LEN, then next cycle done=1, done_abort=0, and done_cnt includes a match on that last bit. Go to RELEASE.
  - din_vld=0: hold.
  - Inputs din/din_vld of non-owners are ignored.
- Latency: hit and done appear exactly 1 cycle after the edge that accepted the bit.
- Match rules:
  - Overlapping matches count: the history is not cleared on a hit. With PATTERN=101011, the stream 10101101011 gives 2 hits.
  - Matches never span frames; the history clears at grant.
- RELEASE (1 cycle):
  - gnt=0, busy=0.
  - ptr <= owner+1 mod NREQ.
  - Go to IDLE. This forces a minimum one-cycle gap between frames.
  - A requester still holding req competes again under round-robin.
- Outputs:
  - gnt, busy, hit, done and all ids/counts are registered.
  - hit_id, done_id, done_cnt and done_abort hold their last value when their strobe is low.
- Widths: matchcnt saturates at FRAME_LEN (unreachable by construction, but required). bitcnt is $clog2(FRAME_LEN+1) bits.
- Simultaneous events: a hit and done on the same final bit both pulse in the same cycle.

Decomposition:
- Package pattern_scan_pkg holds:
  - the state enum (IDLE, SCAN, RELEASE);
  - the default PATTERN and PAT_W constants;
  - the helper width function for id and count widths.
- Sub-module pattern_scan_engine holds the shift history, bit counter, match counter and compare.
  - Inputs: clear, bit, valid.
  - Outputs: hit, count.
  - The arbiter/FSM stays in the top.

Test Plan:
- Reset, then req=0001; owner 0 streams 16 valid bits 1010110101100000 -> gnt=0001 one cycle after req; hit pulses after bits 6 and 11; done=1, done_id=0, done_cnt=2, done_abort=0; gnt=0 the next cycle.
- req=1111 held, every frame all zeros -> grants in order 0,1,2,3,0, each separated by exactly one RELEASE cycle; done_cnt=0 each time.
- Owner 2 with din_vld toggling 1,0,1,0 carrying bits 101011 on the valid cycles -> one hit, 1 cycle after the 6th valid bit; invalid cycles do not advance the count.
- req[1] drops after 5 valid bits -> done=1, done_abort=1, done_id=1, done_cnt=0, then RELEASE and IDLE.
- Pattern 101011 aligned to end on bit 16 -> hit and done in the same cycle with done_cnt=1. A frame ending in 10101 followed by a new frame starting 1 -> no hit (no cross-frame match).
- r asserted in the middle of SCAN -> the next cycle all outputs are 0 and no done is emitted; with req=0100 held, the next grant goes to requester 2 (search from ptr=0).
